// File: rtl/wisc_pkg.sv
// Shared WISC definitions: opcode encodings, the bubble instruction and fetch FSM states.
package wisc_pkg;

    localparam logic [4:0]  OPC_HALT  = 5'b00000;
    localparam logic [4:0]  OPC_NOP   = 5'b00001;
    localparam logic [15:0] NOP_INSTR = {OPC_NOP, 11'd0};

    typedef enum logic [1:0] {
        FETCH,
        HOLD,
        HALTED
    } fetch_state_t;

    function automatic logic isHalt(input logic [15:0] instr);
        return instr[15:11] == OPC_HALT;
    endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: synchronous active-low reset, load enable and bubble insert.
// Bubble wins over load; a bubble keeps the previous PC+2.
module if_id_reg #(
    parameter logic [15:0] NOP_INSTR = 16'h0800
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        load_i,
    input  logic        bubble_i,
    input  logic [15:0] instr_i,
    input  logic [15:0] pcPlus2_i,
    output logic [15:0] instr_o,
    output logic [15:0] pcPlus2_o,
    output logic        valid_o
);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            instr_o   <= NOP_INSTR;
            pcPlus2_o <= 16'h0000;
            valid_o   <= 1'b0;
        end else if (bubble_i) begin
            instr_o <= NOP_INSTR;
            valid_o <= 1'b0;
        end else if (load_i) begin
            instr_o   <= instr_i;
            pcPlus2_o <= pcPlus2_i;
            valid_o   <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, imem handshake, one-entry skid buffer, redirect and HALT.
// Optional misaligned-redirect trap is enabled by defining IF_ALIGN_CHECK_EN.
module fetch_stage #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = wisc_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_rdata,
    input  logic        imem_ack,
    input  logic        stall,
    input  logic        flush,
    input  logic [15:0] redir_pc,
    output logic [15:0] if_instr,
    output logic [15:0] if_pc_plus2,
    output logic        if_valid,
    output logic        if_halted,
    output logic        if_err
);
    import wisc_pkg::*;

    fetch_state_t stateQ;
    logic [15:0]  pcQ;
    logic [15:0]  pcPlus2;
    logic [15:0]  skidInstrQ;
    logic [15:0]  skidPcPlus2Q;
    logic         haltedQ;
    logic [15:0]  redirPc;
    logic         idLoad;
    logic         idBubble;
    logic [15:0]  idInstr;
    logic [15:0]  idPcPlus2;

    assign pcPlus2   = pcQ + 16'd2;
    assign imem_req  = rst_n && (stateQ == FETCH);
    assign imem_addr = pcQ;
    assign if_halted = haltedQ;

`ifdef IF_ALIGN_CHECK_EN
    logic errQ;
    assign redirPc = redir_pc;
    assign if_err  = errQ;
`else
    assign redirPc = {redir_pc[15:1], 1'b0};
    assign if_err  = 1'b0;
`endif

    // IF/ID control; acks are only honoured in FETCH, where a request is outstanding.
    always_comb begin
        idLoad    = 1'b0;
        idBubble  = 1'b0;
        idInstr   = imem_rdata;
        idPcPlus2 = pcPlus2;
        if (flush) begin
            idBubble = 1'b1;
        end else begin
            unique case (stateQ)
                FETCH: begin
                    if (!stall) begin
                        idLoad   = imem_ack;
                        idBubble = !imem_ack;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        idLoad    = 1'b1;
                        idInstr   = skidInstrQ;
                        idPcPlus2 = skidPcPlus2Q;
                    end
                end
                HALTED: idBubble = !stall;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stateQ       <= FETCH;
            pcQ          <= RESET_PC;
            skidInstrQ   <= NOP_INSTR;
            skidPcPlus2Q <= 16'h0000;
            haltedQ      <= 1'b0;
`ifdef IF_ALIGN_CHECK_EN
            errQ         <= 1'b0;
`endif
        end else if (flush) begin
            stateQ  <= FETCH;
            pcQ     <= redirPc;
            haltedQ <= 1'b0;
`ifdef IF_ALIGN_CHECK_EN
            if (redir_pc[0]) begin
                errQ    <= 1'b1;
                stateQ  <= HALTED;
                haltedQ <= 1'b1;
            end
`endif
        end else begin
            case (stateQ)
                FETCH: begin
                    if (imem_ack) begin
                        pcQ <= pcPlus2;
                        if (stall) begin
                            skidInstrQ   <= imem_rdata;
                            skidPcPlus2Q <= pcPlus2;
                            stateQ       <= HOLD;
                        end else if (isHalt(imem_rdata)) begin
                            stateQ  <= HALTED;
                            haltedQ <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        if (isHalt(skidInstrQ)) begin
                            stateQ  <= HALTED;
                            haltedQ <= 1'b1;
                        end else begin
                            stateQ <= FETCH;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    if_id_reg #(
        .NOP_INSTR(NOP_INSTR)
    ) u_if_id_reg (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .load_i   (idLoad),
        .bubble_i (idBubble),
        .instr_i  (idInstr),
        .pcPlus2_i(idPcPlus2),
        .instr_o  (if_instr),
        .pcPlus2_o(if_pc_plus2),
        .valid_o  (if_valid)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage; the imem is modelled by driving ack/rdata directly.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata;
    logic        imem_ack;
    logic        stall;
    logic        flush;
    logic [15:0] redir_pc;
    logic [15:0] if_instr;
    logic [15:0] if_pc_plus2;
    logic        if_valid;
    logic        if_halted;
    logic        if_err;

    int checks = 0;
    int errors = 0;

    logic [15:0] words [3];

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .imem_ack   (imem_ack),
        .stall      (stall),
        .flush      (flush),
        .redir_pc   (redir_pc),
        .if_instr   (if_instr),
        .if_pc_plus2(if_pc_plus2),
        .if_valid   (if_valid),
        .if_halted  (if_halted),
        .if_err     (if_err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        words[0] = 16'h2001;
        words[1] = 16'h2002;
        words[2] = 16'h2003;
        rst_n      = 1'b0;
        imem_ack   = 1'b0;
        imem_rdata = 16'h0000;
        stall      = 1'b0;
        flush      = 1'b0;
        redir_pc   = 16'h0000;

        // Reset state
        step();
        step();
        chk("rst_req", {15'd0, imem_req}, 16'd0);
        chk("rst_valid", {15'd0, if_valid}, 16'd0);
        chk("rst_instr", if_instr, 16'h0800);
        chk("rst_pc2", if_pc_plus2, 16'h0000);
        chk("rst_halted", {15'd0, if_halted}, 16'd0);
        chk("rst_err", {15'd0, if_err}, 16'd0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_req", {15'd0, imem_req}, 16'd1);
        chk("post_rst_addr", imem_addr, 16'h0000);

        // 1: ack every cycle, no stall
        for (int i = 0; i < 3; i++) begin
            chk("seq_addr", imem_addr, 16'(2 * i));
            imem_ack   = 1'b1;
            imem_rdata = words[i];
            step();
            chk("seq_valid", {15'd0, if_valid}, 16'd1);
            chk("seq_instr", if_instr, words[i]);
            chk("seq_pc2", if_pc_plus2, 16'(2 * i + 2));
        end

        // 2: ack under stall goes to the skid buffer
        imem_rdata = 16'h3333;
        stall      = 1'b1;
        step();
        imem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("hold_req", {15'd0, imem_req}, 16'd0);
            chk("hold_instr", if_instr, 16'h2003);
            chk("hold_pc2", if_pc_plus2, 16'h0006);
            if (i < 2) step();
        end
        stall = 1'b0;
        step();
        chk("skid_instr", if_instr, 16'h3333);
        chk("skid_pc2", if_pc_plus2, 16'h0008);
        chk("skid_valid", {15'd0, if_valid}, 16'd1);
        chk("resume_req", {15'd0, imem_req}, 16'd1);
        chk("resume_addr", imem_addr, 16'h0008);
        step();
        chk("bubble_valid", {15'd0, if_valid}, 16'd0);
        chk("bubble_instr", if_instr, 16'h0800);
        chk("bubble_addr", imem_addr, 16'h0008);

        // 4: flush in the same cycle as an ack at pc 8
        imem_ack   = 1'b1;
        imem_rdata = 16'h4000;
        flush      = 1'b1;
        redir_pc   = 16'h0100;
        step();
        flush    = 1'b0;
        imem_ack = 1'b0;
        chk("flush_valid", {15'd0, if_valid}, 16'd0);
        chk("flush_instr", if_instr, 16'h0800);
        chk("flush_addr", imem_addr, 16'h0100);
        chk("flush_req", {15'd0, imem_req}, 16'd1);

        // 3: HALT fetch, then redirect out of HALTED
        imem_ack   = 1'b1;
        imem_rdata = 16'h0000;
        step();
        imem_ack = 1'b0;
        chk("halt_flag", {15'd0, if_halted}, 16'd1);
        chk("halt_instr", if_instr, 16'h0000);
        chk("halt_pc2", if_pc_plus2, 16'h0102);
        chk("halt_req", {15'd0, imem_req}, 16'd0);
        step();
        chk("halt_req2", {15'd0, imem_req}, 16'd0);
        chk("halt_drain", {15'd0, if_valid}, 16'd0);
        flush    = 1'b1;
        redir_pc = 16'h0040;
        step();
        flush = 1'b0;
        chk("unhalt_flag", {15'd0, if_halted}, 16'd0);
        chk("unhalt_addr", imem_addr, 16'h0040);
        chk("unhalt_req", {15'd0, imem_req}, 16'd1);

        // 5: PC wraps modulo 2^16
        flush    = 1'b1;
        redir_pc = 16'hFFFE;
        step();
        flush = 1'b0;
        chk("wrap_addr0", imem_addr, 16'hFFFE);
        imem_ack   = 1'b1;
        imem_rdata = 16'h2222;
        step();
        imem_ack = 1'b0;
        chk("wrap_instr", if_instr, 16'h2222);
        chk("wrap_pc2", if_pc_plus2, 16'h0000);
        chk("wrap_addr", imem_addr, 16'h0000);

        // 6: misaligned redirect
        flush    = 1'b1;
        redir_pc = 16'h0013;
        step();
        flush = 1'b0;
`ifdef IF_ALIGN_CHECK_EN
        chk("align_err", {15'd0, if_err}, 16'd1);
        chk("align_halted", {15'd0, if_halted}, 16'd1);
        chk("align_req", {15'd0, imem_req}, 16'd0);
`else
        chk("align_addr", imem_addr, 16'h0012);
        chk("align_err", {15'd0, if_err}, 16'd0);
        chk("align_req", {15'd0, imem_req}, 16'd1);
`endif
        chk("align_valid", {15'd0, if_valid}, 16'd0);

        // Reset with an ack pending: the ack is ignored
        imem_ack   = 1'b1;
        imem_rdata = 16'h5555;
        rst_n      = 1'b0;
        step();
        chk("rst_ack_valid", {15'd0, if_valid}, 16'd0);
        chk("rst_ack_instr", if_instr, 16'h0800);
        chk("rst_ack_err", {15'd0, if_err}, 16'd0);
        imem_ack = 1'b0;
        rst_n    = 1'b1;
        #1;
        chk("rst_ack_addr", imem_addr, 16'h0000);
        step();
        chk("rst_ack_after", {15'd0, if_valid}, 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
